// File: rtl/wdt_cfg_pkg.sv
// wdt_cfg_pkg: shared select and FSM state types for the WDT configuration arbiter.
package wdt_cfg_pkg;
  typedef enum logic [1:0] {SEL_WDEN, SEL_LIVE, SEL_TOCNT, SEL_AUX} sel_e;
  typedef enum logic [1:0] {ARB, APPLY, RESP} state_e;
endpackage

// File: rtl/wdt_cfg_arbiter_rr.sv
// rr_arbiter: round-robin pick of one requester, searching upward from ptr_i with wrap.
// Ports: req_i request vector, ptr_i search start, en_i enables the grant,
//        gnt_o one-hot grant (zero when disabled or idle), idx_o binary winner index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic found;
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (en_i && !found && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        found = 1'b1;
        idx_o = IW'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
    gnt_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/wdt_cfg_arbiter.sv
// wdt_cfg_arbiter: round-robin shared access to the WDT registers WDEN/WDLIVE/WTOCNT with sequence checking.
// Ports: req_valid/req_sel/req_data per-requester writes, req_ready one-hot accept,
//        rsp_valid/rsp_err one-cycle response, wto timeout in, wd_en/wd_live/wd_tocnt to the WDT,
//        wto_seen sticky timeout flag, busy high outside ARB.
// Optional: define WDT_AUTOKICK_EN to enable the AUX register and periodic auto-kick.
module wdt_cfg_arbiter import wdt_cfg_pkg::*; #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 32,
  parameter int KICK_PERIOD = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_sel,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  input  logic                      wto,
  output logic                      wd_en,
  output logic                      wd_live,
  output logic [DATA_W-1:0]         wd_tocnt,
  output logic                      wto_seen,
  output logic                      busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_e              state_q;
  sel_e                sel_q;
  logic [IW-1:0]       rr_q, win_q, idx;
  logic [DATA_W-1:0]   data_q, tocnt_q;
  logic [NUM_REQ-1:0]  gnt, rsp_valid_q;
  logic                wd_en_q, wd_live_q, wto_seen_q, rsp_err_q;
  logic                apply, set_en, clr_en, live_req, wr_tocnt, aux_err, err, auto_kick;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i(req_valid), .ptr_i(rr_q), .en_i(state_q == ARB), .gnt_o(gnt), .idx_o(idx)
  );
  assign apply    = state_q == APPLY;
  // A simultaneous timeout vetoes enabling and turns the request into an error.
  assign set_en   = sel_q == SEL_WDEN && data_q[0] && tocnt_q != '0 && !wto;
  assign clr_en   = sel_q == SEL_WDEN && !data_q[0];
  assign live_req = apply && sel_q == SEL_LIVE && wd_en_q && data_q != '0;
  assign wr_tocnt = sel_q == SEL_TOCNT && !wd_en_q;
  assign err = (sel_q == SEL_WDEN && data_q[0] && (tocnt_q == '0 || wto))
            || (sel_q == SEL_LIVE && !wd_en_q)
            || (sel_q == SEL_TOCNT && wd_en_q)
            || (sel_q == SEL_AUX && aux_err);
`ifdef WDT_AUTOKICK_EN
  localparam int KW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
  logic          ak_on_q;
  logic [KW-1:0] kcnt_q;
  assign aux_err   = 1'b0;
  assign auto_kick = wd_en_q && ak_on_q && kcnt_q == KW'(KICK_PERIOD - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ak_on_q <= 1'b0;
      kcnt_q  <= '0;
    end else begin
      if (apply && sel_q == SEL_AUX) ak_on_q <= data_q[0];
      kcnt_q <= (!wd_en_q || !ak_on_q || auto_kick || live_req) ? '0 : kcnt_q + 1'b1;
    end
  end
`else
  assign aux_err   = 1'b1;
  assign auto_kick = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      rr_q        <= '0;
      win_q       <= '0;
      sel_q       <= SEL_WDEN;
      data_q      <= '0;
      wd_en_q     <= 1'b0;
      wd_live_q   <= 1'b0;
      tocnt_q     <= '0;
      wto_seen_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      wd_live_q   <= live_req | auto_kick;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ARB: if (|gnt) begin
          win_q   <= idx;
          sel_q   <= sel_e'(req_sel[2*idx +: 2]);
          data_q  <= req_data[DATA_W*idx +: DATA_W];
          state_q <= APPLY;
        end
        APPLY: begin
          if (set_en) wd_en_q <= 1'b1;
          if (clr_en) begin
            wd_en_q    <= 1'b0;
            wto_seen_q <= 1'b0;
          end
          if (wr_tocnt) tocnt_q <= data_q;
          rsp_valid_q <= NUM_REQ'(1) << win_q;
          rsp_err_q   <= err;
          state_q     <= RESP;
        end
        RESP: begin
          rr_q    <= (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
      if (wto) begin
        wd_en_q    <= 1'b0;
        wto_seen_q <= 1'b1;
      end
    end
  end
  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign wd_en     = wd_en_q;
  assign wd_live   = wd_live_q;
  assign wd_tocnt  = tocnt_q;
  assign wto_seen  = wto_seen_q;
  assign busy      = state_q != ARB;
endmodule

// File: tb/tb_wdt_cfg_arbiter.sv
// tb_wdt_cfg_arbiter: randomized and directed self-checking bench for wdt_cfg_arbiter.
module tb_wdt_cfg_arbiter;
  localparam int N = 3, W = 32, KP = 8;
`ifdef WDT_AUTOKICK_EN
  localparam bit AUX_ERR = 1'b0;
`else
  localparam bit AUX_ERR = 1'b1;
`endif
  logic clk = 1'b0, rst = 1'b1, wto = 1'b0;
  logic [N-1:0]   req_valid = '0, req_ready, rsp_valid;
  logic [2*N-1:0] req_sel = '0;
  logic [W*N-1:0] req_data = '0;
  logic           rsp_err, wd_en, wd_live, wto_seen, busy;
  logic [W-1:0]   wd_tocnt;
  int n_chk = 0, n_fail = 0;
  bit m_en, m_seen;
  logic [W-1:0] m_tocnt;
  int m_ptr;
  always #5 clk = ~clk;
  wdt_cfg_arbiter #(.NUM_REQ(N), .DATA_W(W), .KICK_PERIOD(KP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .wto(wto), .wd_en(wd_en),
    .wd_live(wd_live), .wd_tocnt(wd_tocnt), .wto_seen(wto_seen), .busy(busy)
  );
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    wto = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_en = 0; m_seen = 0; m_tocnt = '0; m_ptr = 0;
  endtask
  // Single-requester transaction; called in an ARB cycle, returns in the next ARB cycle.
  task automatic issue(input int r, input int sel, input logic [W-1:0] d, input bit w);
    bit e, lv;
    e = 0; lv = 0;
    case (sel)
      0: if (d[0]) begin
           e = (m_tocnt == 0) || w;
           if (!e) m_en = 1;
         end else begin
           m_en = 0; m_seen = 0;
         end
      1: begin e = !m_en; lv = !e && d != 0; end
      2: begin e = m_en; if (!e) m_tocnt = d; end
      default: e = AUX_ERR;
    endcase
    if (w) begin m_en = 0; m_seen = 1; end
    m_ptr = (r + 1) % N;
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_sel[2*r +: 2] = 2'(sel);
    req_data[W*r +: W] = d;
    #1;
    n_chk++; if (req_ready !== N'(1 << r)) begin n_fail++; $display("FAIL ready r=%0d got %b exp %b", r, req_ready, N'(1 << r)); end
    @(negedge clk);
    req_valid = '0;
    wto = w;
    #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_apply got %b exp 1", busy); end
    @(negedge clk);
    wto = 1'b0;
    #1;
    n_chk++; if (rsp_valid !== N'(1 << r)) begin n_fail++; $display("FAIL rsp_valid sel=%0d got %b exp %b", sel, rsp_valid, N'(1 << r)); end
    n_chk++; if (rsp_err !== e) begin n_fail++; $display("FAIL rsp_err sel=%0d d=%h w=%0d got %b exp %b", sel, d, w, rsp_err, e); end
    n_chk++; if (wd_en !== m_en) begin n_fail++; $display("FAIL wd_en sel=%0d got %b exp %b", sel, wd_en, m_en); end
    n_chk++; if (wd_tocnt !== m_tocnt) begin n_fail++; $display("FAIL wd_tocnt sel=%0d got %h exp %h", sel, wd_tocnt, m_tocnt); end
    n_chk++; if (wto_seen !== m_seen) begin n_fail++; $display("FAIL wto_seen sel=%0d got %b exp %b", sel, wto_seen, m_seen); end
    n_chk++; if (wd_live !== lv) begin n_fail++; $display("FAIL wd_live sel=%0d got %b exp %b", sel, wd_live, lv); end
    @(negedge clk);
    #1;
    n_chk++; if (wd_live !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL pulse_end live=%b rsp=%b exp 0/0", wd_live, rsp_valid); end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if ({wd_en, wd_live, wto_seen, rsp_err, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 00000", {wd_en, wd_live, wto_seen, rsp_err, busy}); end
    n_chk++; if (wd_tocnt !== '0 || req_ready !== '0 || rsp_valid !== '0) begin n_fail++; $display("FAIL reset_vec tocnt=%h ready=%b rsp=%b exp 0", wd_tocnt, req_ready, rsp_valid); end
    do_reset;
  endtask
  task automatic test_directed;
    issue(0, 0, 1, 0);
    issue(1, 2, 32'h100, 0);
    issue(0, 0, 1, 0);
    issue(1, 2, 5, 0);
    issue(0, 1, 1, 0);
    issue(2, 1, 0, 0);
    issue(1, 0, 0, 0);
    issue(0, 0, 1, 1);
    issue(1, 0, 0, 0);
    issue(2, 3, 1, 0);
  endtask
  task automatic test_rr_hold;
    int seq[4];
    int got;
    bit multi;
    do_reset;
    req_sel[1:0] = 2'd1; req_sel[3:2] = 2'd1;
    req_data[W-1:0] = '0; req_data[2*W-1:W] = '0;
    req_valid = 3'b011;
    got = 0; multi = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      #1;
      if ($countones(req_ready) > 1) multi = 1;
      for (int k = 0; k < N; k++) if (req_ready[k]) begin seq[got] = k; got++; end
      if (got < 4) @(negedge clk);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    m_ptr = 2;
    n_chk++; if (got != 4) begin n_fail++; $display("FAIL rr_hold_grants got %0d exp 4", got); end
    for (int i = 0; i < got; i++) begin
      n_chk++; if (seq[i] != i % 2) begin n_fail++; $display("FAIL rr_hold_order[%0d] got %0d exp %0d", i, seq[i], i % 2); end
    end
    n_chk++; if (multi) begin n_fail++; $display("FAIL rr_onehot got multi=1 exp 0"); end
  endtask
  task automatic test_rr_random;
    logic [N-1:0] mask;
    int ew;
    for (int i = 0; i < N; i++) begin
      req_sel[2*i +: 2] = 2'd1;
      req_data[W*i +: W] = '0;
    end
    for (int rnd = 0; rnd < 10; rnd++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      ew = -1;
      for (int k = 0; k < N; k++) if (ew < 0 && mask[(m_ptr + k) % N]) ew = (m_ptr + k) % N;
      req_valid = mask;
      #1;
      n_chk++; if (req_ready !== N'(1 << ew)) begin n_fail++; $display("FAIL rr_rand_grant mask=%b ptr=%0d got %b exp %b", mask, m_ptr, req_ready, N'(1 << ew)); end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      n_chk++; if (rsp_valid !== N'(1 << ew) || rsp_err !== !m_en) begin n_fail++; $display("FAIL rr_rand_rsp got %b/%b exp %b/%b", rsp_valid, rsp_err, N'(1 << ew), !m_en); end
      @(negedge clk);
      m_ptr = (ew + 1) % N;
    end
  endtask
  task automatic test_random;
    int r, sel, pick;
    logic [W-1:0] d;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, N - 1);
`ifdef WDT_AUTOKICK_EN
      sel = $urandom_range(0, 2);
`else
      sel = $urandom_range(0, 3);
`endif
      pick = $urandom_range(0, 3);
      d = (pick == 0) ? '0 : (pick == 1) ? W'(1) : (pick == 2) ? W'(32'h100) : W'($urandom);
      issue(r, sel, d, $urandom_range(0, 7) == 0);
    end
  endtask
  task automatic test_reset_mid;
    bit seen_rsp;
    do_reset;
    issue(0, 2, 32'h55, 0);
    issue(1, 0, 1, 0);
    req_valid = 3'b010;
    req_sel[3:2] = 2'd2;
    req_data[2*W-1:W] = 32'h7;
    #1;
    n_chk++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mid_ready got %b exp 010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({wd_en, wd_live, wto_seen, rsp_err, busy} !== 5'b0 || wd_tocnt !== '0 || rsp_valid !== '0) begin
      n_fail++; $display("FAIL mid_reset flags=%b tocnt=%h rsp=%b exp 0", {wd_en, wd_live, wto_seen, rsp_err, busy}, wd_tocnt, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    m_en = 0; m_seen = 0; m_tocnt = '0; m_ptr = 0;
    seen_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (rsp_valid !== '0) seen_rsp = 1;
      @(negedge clk);
    end
    n_chk++; if (seen_rsp) begin n_fail++; $display("FAIL mid_no_rsp got rsp=1 exp 0"); end
    issue(1, 2, 32'h33, 0);
    issue(2, 0, 1, 0);
  endtask
`ifdef WDT_AUTOKICK_EN
  task automatic test_autokick;
    int last, cnt;
    bit exp;
    do_reset;
    issue(0, 2, 32'h40, 0);
    issue(0, 0, 1, 0);
    issue(1, 3, 1, 0);
    last = -1; cnt = 0;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(negedge clk);
      #1;
      if (wd_live) begin
        if (last >= 0) begin
          n_chk++; if (c - last != KP) begin n_fail++; $display("FAIL ak_period got %0d exp %0d", c - last, KP); end
        end
        last = c; cnt++;
      end
    end
    n_chk++; if (cnt != 4) begin n_fail++; $display("FAIL ak_pulses got %0d exp 4", cnt); end
    repeat (4) @(negedge clk);
    req_valid = 3'b001;
    req_sel[1:0] = 2'd1;
    req_data[W-1:0] = 32'h1;
    #1;
    n_chk++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL ak_kick_ready got %b exp 001", req_ready); end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = '0;
      #1;
      exp = (c == 2) || (c == 10);
      n_chk++; if (wd_live !== exp) begin n_fail++; $display("FAIL ak_restart c=%0d got %b exp %b", c, wd_live, exp); end
    end
  endtask
`endif
  initial begin
    test_reset;
    test_directed;
    test_rr_hold;
    test_rr_random;
    test_random;
    test_reset_mid;
`ifdef WDT_AUTOKICK_EN
    test_autokick;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
